// File: rtl/add_to_acap_pkg.sv
// Shared constants, FSM state type and modular-add helper for the ACAP accumulator.
package add_to_acap_pkg;

  function automatic int calc_ring_size(input int depth);
    return 1 << depth;
  endfunction

  function automatic int calc_chunks(input int depth, input int lanes);
    return (2 << depth) / lanes;
  endfunction

  function automatic int calc_nd(input int lwe_size, input int d_r);
    return lwe_size * d_r;
  endfunction

  function automatic int a_addr_width(input int lwe_size, input int d_r);
    return $clog2(lwe_size * d_r);
  endfunction

  function automatic int secret_addr_width(input int a_addr_w, input int a_w,
                                           input int depth, input int lanes);
    return a_addr_w + a_w + $clog2(calc_chunks(depth, lanes));
  endfunction

  localparam int RING_DEPTH_DEF = 4;
  localparam int LANES_DEF      = 4;
  localparam int LWE_SIZE_DEF   = 4;
  localparam int D_R_DEF        = 2;
  localparam int RING_SIZE      = calc_ring_size(RING_DEPTH_DEF);
  localparam int CHUNKS         = calc_chunks(RING_DEPTH_DEF, LANES_DEF);
  localparam int ND             = calc_nd(LWE_SIZE_DEF, D_R_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acap_state_e;

  // Operands are assumed already reduced (< q); one conditional subtract suffices.
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[31:0];
  endfunction

endpackage

// File: rtl/add_to_acap_shift_reg.sv
// Fixed-depth shift register with asynchronous clear; carries key-alignment info.
module shift_reg #(
  parameter int SHIFT = 2,
  parameter int DATA  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DATA-1:0] in,
  output logic [DATA-1:0] out
);

  logic [DATA-1:0] stages [SHIFT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SHIFT; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in;
      for (int i = 1; i < SHIFT; i++) stages[i] <= stages[i-1];
    end
  end

  assign out = stages[SHIFT-1];

endmodule

// File: rtl/add_to_acap.sv
// FHEW blind-rotation accumulate: streams key words per digit and adds them mod Q.
// Build option ACAP_SKIP_ZERO_EN: skip digits whose value is zero.
module add_to_acap
  import add_to_acap_pkg::*;
#(
  parameter int RING_DEPTH        = RING_DEPTH_DEF,
  parameter int DATA_SIZE         = 16,
  parameter int Q                 = 12289,
  parameter int LANES             = LANES_DEF,
  parameter int LWE_SIZE          = LWE_SIZE_DEF,
  parameter int D_R               = D_R_DEF,
  parameter int A_WIDTH           = 3,
  parameter int A_ADDR_WIDTH      = a_addr_width(LWE_SIZE, D_R),
  parameter int SECRET_ADDR_WIDTH = secret_addr_width(A_ADDR_WIDTH, A_WIDTH, RING_DEPTH, LANES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_enable_bram,
  input  logic [RING_DEPTH:0]          write_addr_input,
  input  logic [DATA_SIZE-1:0]         data_in,
  input  logic                         load_a,
  input  logic [A_WIDTH-1:0]           data_a,
  input  logic [A_ADDR_WIDTH-1:0]      write_addr_a,
  input  logic                         start,
  input  logic [DATA_SIZE*LANES-1:0]   secret_key,
  input  logic [RING_DEPTH:0]          read_out,
  output logic                         done,
  output logic [DATA_SIZE-1:0]         data_out,
  output logic [SECRET_ADDR_WIDTH-1:0] secret_addr
);

  localparam int NCOEF  = 2 * calc_ring_size(RING_DEPTH);
  localparam int NCHUNK = calc_chunks(RING_DEPTH, LANES);
  localparam int NDIG   = calc_nd(LWE_SIZE, D_R);
  localparam int CW     = $clog2(NCHUNK);
  localparam int AW     = RING_DEPTH + 1;
  localparam int PIPE_W = 1 + AW;

  acap_state_e              state;
  logic [A_ADDR_WIDTH-1:0]  k_q;
  logic [CW-1:0]            c_q;
  logic                     drain_q;
  logic                     host_ok;

  logic [DATA_SIZE-1:0]     acc   [NCOEF];
  logic [A_WIDTH-1:0]       a_mem [NDIG];

  logic [NDIG-1:0]          active;
  logic [A_ADDR_WIDTH:0]    search_from;
  logic                     found;
  logic [A_ADDR_WIDTH-1:0]  nxt_k;

  logic [PIPE_W-1:0]        pipe_in;
  logic [PIPE_W-1:0]        pipe_out;
  logic                     key_valid;
  logic [AW-1:0]            key_base;
  logic [DATA_SIZE-1:0]     lane_sum [LANES];

  assign host_ok = (state == ST_IDLE) || (state == ST_DONE);

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
`ifdef ACAP_SKIP_ZERO_EN
      active[i] = |a_mem[i];
`else
      active[i] = 1'b1;
`endif
    end
  end

  // Lowest active digit at or above search_from: first digit on start, next one in ISSUE.
  always_comb begin
    search_from = (state == ST_ISSUE) ? ({1'b0, k_q} + 1'b1) : '0;
    found       = 1'b0;
    nxt_k       = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (i >= int'(search_from) && active[i]) begin
        found = 1'b1;
        nxt_k = A_ADDR_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      drain_q     <= 1'b0;
      done        <= 1'b0;
      secret_addr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done <= 1'b0;
            if (found) begin
              state       <= ST_ISSUE;
              k_q         <= nxt_k;
              c_q         <= '0;
              secret_addr <= {nxt_k, a_mem[nxt_k], CW'(0)};
            end else begin
              state   <= ST_DRAIN;
              drain_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (c_q == CW'(NCHUNK - 1)) begin
            if (found) begin
              k_q         <= nxt_k;
              c_q         <= '0;
              secret_addr <= {nxt_k, a_mem[nxt_k], CW'(0)};
            end else begin
              state   <= ST_DRAIN;
              drain_q <= 1'b0;
            end
          end else begin
            c_q         <= CW'(c_q + 1'b1);
            secret_addr <= {k_q, a_mem[k_q], CW'(c_q + 1'b1)};
          end
        end
        ST_DRAIN: begin
          if (drain_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Key words arrive two cycles after their address; align write target and valid.
  assign pipe_in = {state == ST_ISSUE, AW'(int'(c_q) * LANES)};

  shift_reg #(
    .SHIFT (2),
    .DATA  (PIPE_W)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .in    (pipe_in),
    .out   (pipe_out)
  );

  assign key_valid = pipe_out[PIPE_W-1];
  assign key_base  = pipe_out[AW-1:0];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_sum[l] = DATA_SIZE'(mod_add(32'(acc[key_base + AW'(l)]),
                                       32'(secret_key[l*DATA_SIZE +: DATA_SIZE]),
                                       32'(Q)));
    end
  end

  always_ff @(posedge clk) begin
    if (host_ok && write_enable_bram) acc[write_addr_input] <= data_in;
    if (key_valid) begin
      for (int l = 0; l < LANES; l++) acc[key_base + AW'(l)] <= lane_sum[l];
    end
  end

  always_ff @(posedge clk) begin
    if (host_ok && load_a) a_mem[write_addr_a] <= data_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else       data_out <= acc[read_out];
  end

endmodule

// File: tb/tb_add_to_acap.sv
// Directed bench for add_to_acap: key-store model, accumulator model, read scoreboard.
module tb_add_to_acap;

  localparam int DW  = 16;
  localparam int QM  = 12289;
  localparam int LN  = 4;
  localparam int NC  = 32;
  localparam int NCH = 8;
  localparam int NDG = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable_bram;
  logic [4:0]  write_addr_input;
  logic [DW-1:0] data_in;
  logic        load_a;
  logic [2:0]  data_a;
  logic [2:0]  write_addr_a;
  logic        start;
  logic [DW*LN-1:0] secret_key;
  logic [4:0]  read_out;
  logic        done;
  logic [DW-1:0] data_out;
  logic [8:0]  secret_addr;

  int n_checks = 0;
  int n_err    = 0;

  add_to_acap dut (
    .clk               (clk),
    .reset             (reset),
    .write_enable_bram (write_enable_bram),
    .write_addr_input  (write_addr_input),
    .data_in           (data_in),
    .load_a            (load_a),
    .data_a            (data_a),
    .write_addr_a      (write_addr_a),
    .start             (start),
    .secret_key        (secret_key),
    .read_out          (read_out),
    .done              (done),
    .data_out          (data_out),
    .secret_addr       (secret_addr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Key store model: 2-cycle registered read, lane l = (addr + l) mod Q
  logic [8:0] ka1, ka2;
  bit key_force = 1'b0;

  always @(posedge clk) begin
    ka1 <= secret_addr;
    ka2 <= ka1;
  end

  always_comb begin
    for (int l = 0; l < LN; l++)
      secret_key[l*DW +: DW] = key_force ? DW'(1) : DW'((int'(ka2) + l) % QM);
  end

  // Reference state
  int m_acc [NC];
  int m_a   [NDG];
  int exp_last_addr = 0;

  // Scoreboard
  logic [DW-1:0] exp_q [$];
  int            tag_q [$];
  logic          rd_req = 1'b0;
  logic          rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (rd_req_d) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_underflow: data_out=%0d with no expected entry", data_out);
      end else begin
        logic [DW-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL rd_acc[%0d]: got %0d expected %0d", t, data_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic write_acc_all();
    for (int j = 0; j < NC; j++) begin
      @(negedge clk);
      write_enable_bram = 1'b1;
      write_addr_input  = 5'(j);
      data_in           = DW'(m_acc[j]);
    end
    @(negedge clk);
    write_enable_bram = 1'b0;
  endtask

  task automatic write_digits_all();
    for (int k = 0; k < NDG; k++) begin
      @(negedge clk);
      load_a       = 1'b1;
      write_addr_a = 3'(k);
      data_a       = 3'(m_a[k]);
    end
    @(negedge clk);
    load_a = 1'b0;
  endtask

  task automatic read_all(input string name);
    for (int j = 0; j < NC; j++) begin
      @(negedge clk);
      read_out = 5'(j);
      rd_req   = 1'b1;
      exp_q.push_back(DW'(m_acc[j]));
      tag_q.push_back(j);
    end
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check({name, "_sb_drain"}, exp_q.size(), 0);
  endtask

  // Accumulator model: walks digits in order, adds key lanes mod Q.
  task automatic model_run(output int lat);
    int p = 0;
    for (int k = 0; k < NDG; k++) begin
      bit proc;
`ifdef ACAP_SKIP_ZERO_EN
      proc = (m_a[k] != 0);
`else
      proc = 1'b1;
`endif
      if (proc) begin
        p++;
        for (int c = 0; c < NCH; c++) begin
          int addr;
          addr = k * 64 + m_a[k] * 8 + c;
          exp_last_addr = addr;
          for (int l = 0; l < LN; l++) begin
            int key;
            key = key_force ? 1 : (addr + l) % QM;
            m_acc[c*LN + l] = (m_acc[c*LN + l] + key) % QM;
          end
        end
      end
    end
    lat = p * NCH + 3;
  endtask

  // Pulses start and counts cycles to done; optionally disturbs the run at cycle disturb_at.
  task automatic run_check(input string name, input int exp_lat, input int disturb_at);
    int  cnt;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt  = 1;
    seen = 1'b0;
    while (cnt < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cnt == disturb_at) begin
        write_enable_bram = 1'b1;
        write_addr_input  = 5'd0;
        data_in           = DW'(5);
        load_a            = 1'b1;
        write_addr_a      = 3'd0;
        data_a            = 3'd3;
        start             = 1'b1;
      end else begin
        write_enable_bram = 1'b0;
        load_a            = 1'b0;
        start             = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    write_enable_bram = 1'b0;
    load_a            = 1'b0;
    start             = 1'b0;
    check({name, "_latency"}, seen ? cnt : -1, exp_lat);
    check({name, "_last_addr"}, 32'(secret_addr), exp_last_addr);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, 32'(done), 1);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    write_enable_bram = 1'b0;
    write_addr_input  = '0;
    data_in           = '0;
    load_a            = 1'b0;
    data_a            = '0;
    write_addr_a      = '0;
    start             = 1'b0;
    read_out          = '0;

    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 0);
    check("rst_secret_addr", 32'(secret_addr), 0);
    check("rst_data_out", 32'(data_out), 0);
    reset = 1'b0;
    exp_last_addr = 0;

    // All-zero accumulator and digits
    for (int j = 0; j < NC; j++) m_acc[j] = 0;
    for (int k = 0; k < NDG; k++) m_a[k] = 0;
    write_acc_all();
    write_digits_all();
    model_run(lat);
`ifdef ACAP_SKIP_ZERO_EN
    run_check("zero", 3, -1);
`else
    run_check("zero", 67, -1);
`endif
    read_all("zero");

    // Ramp accumulator, single digit a[0]=1: acc[4c+l] = 4c+l + 8+c + l
    for (int j = 0; j < NC; j++) m_acc[j] = j;
    for (int k = 0; k < NDG; k++) m_a[k] = 0;
    m_a[0] = 1;
    write_acc_all();
    write_digits_all();
    model_run(lat);
`ifdef ACAP_SKIP_ZERO_EN
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < LN; l++) m_acc[4*c + l] = 4*c + l + 8 + c + l;
    exp_last_addr = 15;
    run_check("ramp", 11, -1);
`else
    run_check("ramp", lat, -1);
`endif
    read_all("ramp");

    // Wrap: acc = Q-1 everywhere, key lanes forced to 1
    key_force = 1'b1;
    for (int j = 0; j < NC; j++) m_acc[j] = QM - 1;
    write_acc_all();
    model_run(lat);
`ifdef ACAP_SKIP_ZERO_EN
    for (int j = 0; j < NC; j++) m_acc[j] = 0;
`endif
    run_check("wrap", lat, -1);
    read_all("wrap");
    key_force = 1'b0;

    // All digits 7: every digit processed in either build
    for (int j = 0; j < NC; j++) m_acc[j] = j;
    for (int k = 0; k < NDG; k++) m_a[k] = 7;
    write_acc_all();
    write_digits_all();
    model_run(lat);
    run_check("all7", 67, -1);
    read_all("all7");

    // Host writes and a second start during ISSUE are ignored
    for (int j = 0; j < NC; j++) m_acc[j] = 3 * j + 1;
    m_a[0] = 1; m_a[1] = 0; m_a[2] = 3; m_a[3] = 0;
    m_a[4] = 0; m_a[5] = 5; m_a[6] = 0; m_a[7] = 2;
    write_acc_all();
    write_digits_all();
    model_run(lat);
    run_check("disturb", lat, 5);
    read_all("disturb");

    // Reset mid-run, then a normal run with digit memory retained
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_done", 32'(done), 0);
    check("midrst_secret_addr", 32'(secret_addr), 0);
    check("midrst_data_out", 32'(data_out), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_last_addr = 0;
    for (int j = 0; j < NC; j++) m_acc[j] = (j * 97) % QM;
    write_acc_all();
    model_run(lat);
    run_check("after_rst", lat, -1);
    read_all("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
